// File: rtl/median_filter_9x9_ctrl.sv
// -----------------------------------------------------------------------------
// median_filter_9x9_ctrl
//
// Frame-level sequencer for a 9x9 median filter. It follows the raster
// position of the upstream pixel stream and tells the median calculator when
// a full 9x9 window lies inside the image. It counts the medians that come
// back and flags the end of the frame. A frame is started by start_i. It ends
// with a frame_done_o pulse once every expected median has returned. It ends
// with a sticky err_o if the drain phase times out.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   start_i       frame start pulse (only honoured in IDLE)
//   done_i        one upstream pixel per asserted cycle, raster order
//   calc_done_i   one median result returned per asserted cycle
//   win_valid_o   registered one-cycle pulse: the last pixel closed a full window
//   row_o, col_o  raster position of the last accepted pixel
//   out_cnt_o     medians received this frame (saturates at the expected count)
//   busy_o        high in FILL, RUN and DRAIN
//   frame_done_o  one-cycle pulse in DONE
//   err_o         sticky error flag (cleared only by rst)
//   state_o       debug view of the FSM: 0 IDLE, 1 FILL, 2 RUN, 3 DRAIN, 4 DONE
//
// Handshake: done_i and calc_done_i are single-cycle valid strobes with no
// back-pressure; every asserted cycle is one event, and this block is always
// ready to take it. It accepts done_i only in FILL/RUN. It accepts calc_done_i
// in FILL/RUN/DRAIN, plus DONE for error detection.
// -----------------------------------------------------------------------------
module median_filter_9x9_ctrl #(
   parameter int IMG_W    = 64,
   parameter int IMG_H    = 64,
   parameter int CNT_W    = 16,
   parameter int DRAIN_TO = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             done_i,
   input  logic             calc_done_i,
   output logic             win_valid_o,
   output logic [CNT_W-1:0] row_o,
   output logic [CNT_W-1:0] col_o,
   output logic [CNT_W-1:0] out_cnt_o,
   output logic             busy_o,
   output logic             frame_done_o,
   output logic             err_o,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int DT_W = $clog2(DRAIN_TO + 1);

   localparam logic [CNT_W-1:0] N_EXP    = CNT_W'((IMG_W - 8) * (IMG_H - 8));
   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
   localparam logic [CNT_W-1:0] WIN_EDGE = CNT_W'(8);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [DT_W-1:0]  DT_LAST  = DT_W'(DRAIN_TO - 1);
   localparam logic [DT_W-1:0]  DT_ONE   = DT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] nxt_row_q, nxt_row_d;   // position the next pixel will take
   logic [CNT_W-1:0] nxt_col_q, nxt_col_d;
   logic [CNT_W-1:0] row_q, row_d;           // position of the last accepted pixel
   logic [CNT_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic [DT_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic             win_q, win_d;
   logic             err_q, err_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         nxt_row_q   <= '0;
         nxt_col_q   <= '0;
         row_q       <= '0;
         col_q       <= '0;
         out_cnt_q   <= '0;
         drain_cnt_q <= '0;
         win_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         nxt_row_q   <= nxt_row_d;
         nxt_col_q   <= nxt_col_d;
         row_q       <= row_d;
         col_q       <= col_d;
         out_cnt_q   <= out_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         win_q       <= win_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      nxt_row_d   = nxt_row_q;
      nxt_col_d   = nxt_col_q;
      row_d       = row_q;
      col_d       = col_q;
      out_cnt_d   = out_cnt_q;
      drain_cnt_d = drain_cnt_q;
      win_d       = 1'b0;
      err_d       = err_q;

      case (state_q)
         S_IDLE: begin
            // A pixel arriving together with start_i is deliberately dropped.
            if (start_i) begin
               state_d   = S_FILL;
               nxt_row_d = '0;
               nxt_col_d = '0;
               row_d     = '0;
               col_d     = '0;
               out_cnt_d = '0;
            end
         end
         S_FILL, S_RUN: begin
            if (done_i) begin
               row_d = nxt_row_q;
               col_d = nxt_col_q;
               // Window is centred 4 pixels back, so it fits once both
               // coordinates of the newest pixel reach 8.
               win_d = (nxt_row_q >= WIN_EDGE) && (nxt_col_q >= WIN_EDGE);
               if (nxt_col_q == LAST_COL) begin
                  nxt_col_d = '0;
                  nxt_row_d = nxt_row_q + ONE;
               end else begin
                  nxt_col_d = nxt_col_q + ONE;
               end
               if ((nxt_row_q == LAST_ROW) && (nxt_col_q == LAST_COL)) begin
                  state_d     = S_DRAIN;
                  drain_cnt_d = '0;
               end else if ((state_q == S_FILL) && (nxt_row_q == WIN_EDGE)) begin
                  state_d = S_RUN;
               end
            end
         end
         S_DRAIN: begin
            if (out_cnt_q == N_EXP) begin
               state_d = S_DONE;
            end else if (drain_cnt_q == DT_LAST) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + DT_ONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Result counting runs independently of pixel acceptance, so a
      // calc_done_i coinciding with done_i is still counted. DONE only
      // exists for one cycle at count N, so anything arriving there is
      // an overflow.
      if ((state_q != S_IDLE) && calc_done_i) begin
         if (out_cnt_q == N_EXP) begin
            err_d = 1'b1;
         end else begin
            out_cnt_d = out_cnt_q + ONE;
         end
      end
   end

   assign win_valid_o  = win_q;
   assign row_o        = row_q;
   assign col_o        = col_q;
   assign out_cnt_o    = out_cnt_q;
   assign busy_o       = (state_q == S_FILL) || (state_q == S_RUN) || (state_q == S_DRAIN);
   assign frame_done_o = (state_q == S_DONE);
   assign err_o        = err_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_median_filter_9x9_ctrl.sv
// -----------------------------------------------------------------------------
// tb_median_filter_9x9_ctrl
//
// Bench for median_filter_9x9_ctrl on a 10x10 image (4 windows per frame).
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point, so each sample shows the result of the edge just taken.
// The reference model counts accepted pixels and derives (row, col) from the
// pixel index with plain division. Window positions are held in exp_q.
// -----------------------------------------------------------------------------
module tb_median_filter_9x9_ctrl;

   localparam int W    = 10;
   localparam int H    = 10;
   localparam int CW   = 16;
   localparam int DTO  = 32;
   localparam int NWIN = (W - 8) * (H - 8);
   localparam int NPIX = W * H;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic          done_i;
   logic          calc_done_i;
   logic          win_valid_o;
   logic [CW-1:0] row_o;
   logic [CW-1:0] col_o;
   logic [CW-1:0] out_cnt_o;
   logic          busy_o;
   logic          frame_done_o;
   logic          err_o;
   logic [2:0]    state_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit exp_err;
   logic [15:0] exp_q[$];

   median_filter_9x9_ctrl #(
      .IMG_W(W), .IMG_H(H), .CNT_W(CW), .DRAIN_TO(DTO)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .done_i(done_i),
      .calc_done_i(calc_done_i), .win_valid_o(win_valid_o), .row_o(row_o),
      .col_o(col_o), .out_cnt_o(out_cnt_o), .busy_o(busy_o),
      .frame_done_o(frame_done_o), .err_o(err_o), .state_o(state_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_win"},   int'(win_valid_o),  0);
      check({tag, "_row"},   int'(row_o),        0);
      check({tag, "_col"},   int'(col_o),        0);
      check({tag, "_cnt"},   int'(out_cnt_o),    0);
      check({tag, "_busy"},  int'(busy_o),       0);
      check({tag, "_fdone"}, int'(frame_done_o), 0);
      check({tag, "_err"},   int'(err_o),        0);
      check({tag, "_state"}, int'(state_o),      0);
   endtask

   task automatic do_reset(input string tag);
      start_i = 1'b0; done_i = 1'b0; calc_done_i = 1'b0;
      rst = 1'b1;
      #2;
      check_zero(tag);
      step();
      step();
      rst = 1'b0;
      exp_err = 1'b0;
   endtask

   // ---------------- frame driver + model + scoreboard ----------------
   // gap: 0 continuous, 1 one pixel every 3 cycles, 2 random
   // n_ret: medians returned; extra: send one more straight after the last
   // rst_at: pixel count at which rst is pulsed (-1 = never)
   task automatic run_frame(input string tag, input int gap, input int n_ret,
                            input bit extra, input int rst_at,
                            input bit mid_start, input bit start_pix);
      int idx, exp_cnt, prow, pcol, win_cnt, fd_cnt, drain_busy, drain_cyc;
      int ret_sched, ret_applied, budget;
      int ret_q[$];
      bit exp_win, ended;
      logic [15:0] pos;

      exp_q = {16'h0808, 16'h0809, 16'h0908, 16'h0909};
      idx = 0; exp_cnt = 0; prow = 0; pcol = 0; win_cnt = 0; fd_cnt = 0;
      drain_busy = 0; drain_cyc = 0; ret_sched = 0; ret_applied = 0;
      budget = 0; ended = 1'b0;

      start_i = 1'b1; done_i = start_pix; calc_done_i = 1'b0;
      step();
      check({tag, "_start_busy"}, int'(busy_o),    1);
      check({tag, "_start_row"},  int'(row_o),     0);
      check({tag, "_start_col"},  int'(col_o),     0);
      check({tag, "_start_cnt"},  int'(out_cnt_o), 0);

      while (!ended && budget < 800) begin
         case (gap)
            0:       done_i = (idx < NPIX);
            1:       done_i = (idx < NPIX) && ((cyc % 3) == 0);
            default: done_i = (idx < NPIX) && ($urandom_range(0, 1) == 1);
         endcase
         start_i = mid_start && done_i && (idx == 90);
         calc_done_i = (ret_q.size() > 0) && (ret_q[0] <= cyc);
         if (calc_done_i) begin
            void'(ret_q.pop_front());
            ret_applied++;
            if (extra && ret_applied == NWIN) ret_q.push_front(cyc + 1);
         end
         step();
         budget++;

         // model: pixel acceptance and result counting
         exp_win = 1'b0;
         if (done_i && idx < NPIX) begin
            prow = idx / W;
            pcol = idx % W;
            exp_win = (prow >= 8) && (pcol >= 8);
            idx++;
         end
         if (calc_done_i) begin
            if (exp_cnt == NWIN) exp_err = 1'b1;
            else exp_cnt++;
         end
         if (idx == NPIX && exp_cnt < NWIN) begin
            drain_cyc++;
            if (drain_cyc == DTO + 1) exp_err = 1'b1;
         end

         check({tag, "_win"}, int'(win_valid_o), int'(exp_win));
         check({tag, "_row"}, int'(row_o),       prow);
         check({tag, "_col"}, int'(col_o),       pcol);
         check({tag, "_cnt"}, int'(out_cnt_o),   exp_cnt);
         check({tag, "_err"}, int'(err_o),       int'(exp_err));

         if (win_valid_o) begin
            win_cnt++;
            if (exp_q.size() == 0) begin
               check({tag, "_win_unexpected"}, 1, 0);
            end else begin
               pos = exp_q.pop_front();
               check({tag, "_win_pos"}, int'({row_o[7:0], col_o[7:0]}), int'(pos));
            end
            if (ret_sched < n_ret) begin
               ret_q.push_back(cyc + ((gap == 2) ? int'($urandom_range(1, 8)) : 5));
               ret_sched++;
            end
         end
         if (frame_done_o) begin
            fd_cnt++;
            check({tag, "_fdone_cnt"}, int'(out_cnt_o), NWIN);
         end
         if (idx == NPIX && busy_o) drain_busy++;

         if (rst_at >= 0 && idx == rst_at) begin
            start_i = 1'b0; done_i = 1'b0; calc_done_i = 1'b0;
            #2;
            rst = 1'b1;
            #1;
            check_zero({tag, "_async"});
            step();
            step();
            rst = 1'b0;
            exp_err = 1'b0;
            return;
         end
         if (idx == NPIX && state_o == 3'd0) ended = 1'b1;
      end
      start_i = 1'b0; done_i = 1'b0; calc_done_i = 1'b0;

      check({tag, "_ended"},   int'(ended),    1);
      check({tag, "_nwin"},    win_cnt,        NWIN);
      check({tag, "_fdones"},  fd_cnt,         (n_ret >= NWIN) ? 1 : 0);
      check({tag, "_endcnt"},  int'(out_cnt_o), (n_ret >= NWIN) ? NWIN : n_ret);
      check({tag, "_endbusy"}, int'(busy_o),   0);
      check({tag, "_endst"},   int'(state_o),  0);
      if (n_ret < NWIN) begin
         check({tag, "_drain_len"}, drain_busy, DTO);
         check({tag, "_to_err"},    int'(err_o), 1);
      end
      if (extra) check({tag, "_extra_err"}, int'(err_o), 1);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic start, done, calc;
      int   busy, row, col, cnt, win;
   } vec_t;

   vec_t tbl[10];

   initial begin
      // From reset: nothing moves before start, the pixel coinciding with
      // start is dropped, and start inside FILL is ignored.
      tbl[0] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 1, 0, 0, 0, 0};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 0};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 1, 0, 1, 0, 0};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 1, 0, 1, 1, 0};
      tbl[6] = '{1'b0, 1'b1, 1'b1, 1, 0, 2, 2, 0};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 1, 0, 3, 2, 0};
      tbl[8] = '{1'b1, 1'b0, 1'b0, 1, 0, 3, 2, 0};
      tbl[9] = '{1'b0, 1'b0, 1'b0, 1, 0, 3, 2, 0};

      exp_err = 1'b0;
      do_reset("por");

      for (int i = 0; i < 10; i++) begin
         start_i = tbl[i].start; done_i = tbl[i].done; calc_done_i = tbl[i].calc;
         step();
         check($sformatf("tbl%0d_busy", i), int'(busy_o),      tbl[i].busy);
         check($sformatf("tbl%0d_row", i),  int'(row_o),       tbl[i].row);
         check($sformatf("tbl%0d_col", i),  int'(col_o),       tbl[i].col);
         check($sformatf("tbl%0d_cnt", i),  int'(out_cnt_o),   tbl[i].cnt);
         check($sformatf("tbl%0d_win", i),  int'(win_valid_o), tbl[i].win);
      end
      do_reset("tblrst");

      run_frame("norm",   0, 4, 1'b0, -1, 1'b0, 1'b0);
      run_frame("gap",    1, 4, 1'b0, -1, 1'b1, 1'b0);
      run_frame("spix",   0, 4, 1'b0, -1, 1'b0, 1'b1);
      run_frame("rstmid", 0, 4, 1'b0, 50, 1'b0, 1'b0);
      run_frame("post",   0, 4, 1'b0, -1, 1'b0, 1'b0);
      run_frame("short",  0, 3, 1'b0, -1, 1'b0, 1'b0);
      do_reset("rst2");
      run_frame("extra",  0, 4, 1'b1, -1, 1'b0, 1'b0);
      do_reset("rst3");
      for (int k = 0; k < 3; k++) begin
         run_frame($sformatf("rnd%0d", k), 2, 4, 1'b0, -1, 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
